uart_tx_tick: RTL and testbench
===============================

# uart_tx_tick

Asynchronous-serial transmitter timed entirely by an external one-cycle enable pulse. Sits directly downstream of the clock-dividing pulse generator: that block's `pulse` output drives `baud_tick` here, one pulse per bit period. Accepts bytes over a valid/ready handshake into a one-entry holding register, then shifts out framed 8N1-style characters on `tx`. Every line transition happens on a clock edge where `baud_tick` is high, so back-to-back frames carry no idle gap.

## Interface

- `data_bits`, default 8: data bits per frame, legal 5..9.
- `parity`, default 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `stop_bits`, default 1: stop bits per frame, legal 1 or 2.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `baud_tick`  in  1  one-cycle bit-period pulse. Must be low for at least one cycle between pulses.
- `data`  in  `data_bits`  character to send, LSB first.
- `valid`  in  1  `data` is valid.
- `ready`  out  1  holding register is empty.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is on the line.

## Operation

- Handshake
  - A transfer occurs on a rising edge with `valid && ready`; `data` is captured into the holding register.
  - `ready` = holding register empty. It drops the cycle after the transfer.
  - Once `valid` is asserted, `data` must be held stable until the transfer.
- Engine states:
  - IDLE: `tx`=1, `busy`=0. On `baud_tick` with the holding register full:
    - copy the holding register to the shifter and empty the holding register;
    - `tx`<=0; go to START.
  - START: on tick, `tx`<=shifter[0], bit index<=0, go to DATA.
  - DATA: on tick, if index < `data_bits`-1:
    - shift right, index+1, `tx`<=next bit;
    - otherwise go to PARITY (`tx`<=parity bit) if `parity`≠0, else to STOP (`tx`<=1).
  - PARITY: on tick, `tx`<=1, go to STOP.
    - Odd mode: total ones in data+parity is odd.
    - Even mode: that total is even.
    - Parity is computed from the character as loaded, not from the shifted state.
  - STOP: hold `tx`=1 for `stop_bits` tick periods. On the tick ending the last stop bit:
    - if the holding register is full, load it and go directly to START with `tx`<=0 (no gap);
    - otherwise go to IDLE.
- `busy` is high in START, DATA, PARITY and STOP.
- Frame length is 1 + `data_bits` + (`parity`≠0) + `stop_bits` tick periods.
- `baud_tick` is ignored in IDLE when the holding register is empty.
- The holding register can be refilled as soon as it has been copied to the shifter. A new byte can therefore be accepted during the current frame.
- Bit index is a clog2(`data_bits`)-bit counter; stop counter is 1 bit. No wrap occurs in legal configurations.

## Timing

- Reset values: `tx`=1, `ready`=1, `busy`=0, holding register empty, engine IDLE.
- Reset mid-frame: `tx` returns high immediately (asynchronous) and the pending byte is discarded. After release, the next frame starts only on a fresh transfer plus tick.
- Transfer at edge E: the start bit begins at the first edge after E where `baud_tick`=1.
  - A tick sampled at edge E itself does not start the frame, because the holding register was still empty at E.
- `tx`, `busy` and `ready` are registered outputs; none depends combinationally on an input.
- Transfer and tick coincident while in STOP's final tick:
  - the byte was not in the holding register at that edge, so the engine goes to IDLE;
  - the new byte starts on the next tick.
- Throughput with `valid` held high: one frame per frame length, no idle ticks between frames.

## Test plan

- Defaults, `baud_tick` every 4 clocks, send 0x55:
  - `tx` per tick = 0,1,0,1,0,1,0,1,0,1 then idle high;
  - each level lasts exactly 4 clocks;
  - `busy` is high for exactly 40 clocks.
- Two bytes 0xA5, 0x3C with `valid` held high:
  - second byte accepted during the first frame;
  - the second start bit immediately follows the first stop bit;
  - `ready` deasserts, then reasserts after the second load.
- Parity: `parity`=2 with 0x07 -> parity bit 1. `parity`=1 with 0x07 -> parity bit 0. `parity`=1 with 0x00 -> 1.
- `stop_bits`=2, `data_bits`=7, send 0x7F: frame is 10 ticks long, with 2 high stop periods before the next start.
- Transfer on the same edge as a tick: start bit begins at the following tick, not that one. Tick with no data pending: `tx` stays 1 and `busy` stays 0.
- Assert `rst` mid-DATA with a byte pending:
  - `tx`=1, `ready`=1, `busy`=0 within the same cycle;
  - no further frame after release until a new transfer.

Source files
------------

// File: rtl/uart_tx_tick.sv
// Tick-timed asynchronous serial transmitter.
// A one-entry holding register decouples the valid/ready handshake from the
// shift engine. Every change on tx happens on a clock edge that carries a
// baud_tick pulse, so consecutive frames follow each other with no idle gap.
module uart_tx_tick #(
  parameter int data_bits = 8,
  parameter int parity    = 0,
  parameter int stop_bits = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [data_bits-1:0] data,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int IDX_W = (data_bits > 1) ? $clog2(data_bits) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(data_bits - 1);
  localparam logic             LAST_STOP = 1'(stop_bits - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state;
  logic                 hold_full;
  logic [data_bits-1:0] hold_q;
  logic [data_bits-1:0] shift_q;
  logic                 par_q;
  logic [IDX_W-1:0]     idx;
  logic                 stop_cnt;
  logic                 take;
  logic                 load;

  // Parity bit for a whole character: odd mode makes the total ones odd,
  // even mode makes it even.
  function automatic logic calc_parity(input logic [data_bits-1:0] d);
    if (parity == 1) return ~(^d);
    return ^d;
  endfunction

  assign take  = valid && ready;
  // The shifter is reloaded either from IDLE or straight out of the last stop
  // bit; both only on a tick and only if the holding register was already full.
  assign load  = baud_tick && hold_full &&
                 ((state == S_IDLE) || ((state == S_STOP) && (stop_cnt == LAST_STOP)));
  assign ready = ~hold_full;

  // Holding-register occupancy: filled by a transfer, emptied by a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       hold_full <= 1'b0;
    else if (load) hold_full <= 1'b0;
    else if (take) hold_full <= 1'b1;
  end

  // Character storage and shifter; parity is latched from the unshifted byte.
  always_ff @(posedge clk) begin
    if (take) hold_q <= data;
    if (load) begin
      shift_q <= hold_q;
      par_q   <= calc_parity(hold_q);
    end else if (baud_tick && (state == S_DATA) && (idx < LAST_IDX)) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Frame sequencer: advances one bit period per baud_tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      idx      <= '0;
      stop_cnt <= 1'b0;
    end else if (baud_tick) begin
      case (state)
        S_IDLE: begin
          if (hold_full) begin
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= S_START;
          end
        end
        S_START: begin
          tx    <= shift_q[0];
          idx   <= '0;
          state <= S_DATA;
        end
        S_DATA: begin
          if (idx < LAST_IDX) begin
            idx <= idx + IDX_W'(1);
            tx  <= shift_q[1];
          end else if (parity != 0) begin
            tx    <= par_q;
            state <= S_PARITY;
          end else begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= S_STOP;
          end
        end
        S_PARITY: begin
          tx       <= 1'b1;
          stop_cnt <= 1'b0;
          state    <= S_STOP;
        end
        S_STOP: begin
          if (stop_cnt != LAST_STOP) begin
            stop_cnt <= stop_cnt + 1'b1;
          end else if (hold_full) begin
            tx    <= 1'b0;
            state <= S_START;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_tick.sv
// Bench for uart_tx_tick: four instances (default 8N1, even parity, odd
// parity, 7 data bits with 2 stop bits) share clock, reset and baud_tick.
// Expected frames go into a scoreboard queue; per-instance line decoders pop
// and compare each frame they recover from tx.
module tb_uart_tx_tick;

  typedef struct {
    int          id;
    logic [11:0] bits;
    int          gap;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            baud_tick;
  logic [3:0]      valid_v;
  logic [3:0][8:0] data_v;
  logic [3:0]      ready_v, tx_v, busy_v;
  logic            r0, r1, r2, r3, t0, t1, t2, t3, b0, b1, b2, b3;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  int   tcnt = 0;

  always #5 clk = ~clk;

  uart_tx_tick #(.data_bits(8), .parity(0), .stop_bits(1)) u0 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data(data_v[0][7:0]),
    .valid(valid_v[0]), .ready(r0), .tx(t0), .busy(b0));
  uart_tx_tick #(.data_bits(8), .parity(2), .stop_bits(1)) u1 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data(data_v[1][7:0]),
    .valid(valid_v[1]), .ready(r1), .tx(t1), .busy(b1));
  uart_tx_tick #(.data_bits(8), .parity(1), .stop_bits(1)) u2 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data(data_v[2][7:0]),
    .valid(valid_v[2]), .ready(r2), .tx(t2), .busy(b2));
  uart_tx_tick #(.data_bits(7), .parity(0), .stop_bits(2)) u3 (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .data(data_v[3][6:0]),
    .valid(valid_v[3]), .ready(r3), .tx(t3), .busy(b3));

  assign ready_v = {r3, r2, r1, r0};
  assign tx_v    = {t3, t2, t1, t0};
  assign busy_v  = {b3, b2, b1, b0};

  // baud_tick: one pulse every 4 clocks, changed just after the rising edge
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % 4;
      baud_tick = (tcnt == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int id, input logic [11:0] bits, input int gap);
    exp_t e;
    e.id = id; e.bits = bits; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic check_frame(input int k, input logic [11:0] fr, input int gap);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL frame: unexpected frame on dut%0d bits %0h", k, fr);
    end else begin
      e = sb.pop_front();
      if (e.id != k || e.bits !== fr) begin
        errors++;
        $display("FAIL frame: dut%0d bits %0h expected dut%0d bits %0h", k, fr, e.id, e.bits);
      end
      if (e.gap >= 0) check("gap", gap, e.gap);
    end
  endtask

  // Recover frames from tx by sampling at the end of every bit period
  task automatic decode(input int k, input int len);
    logic [11:0] fr;
    int n;
    int gap;
    bit infr;
    fr = '0; n = 0; gap = 0; infr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        infr = 1'b0; n = 0; gap = 0;
      end else if (baud_tick) begin
        if (!infr) begin
          if (tx_v[k] == 1'b0) begin
            infr = 1'b1; fr = '0; n = 1;
          end else begin
            gap++;
          end
        end else begin
          fr[n] = tx_v[k];
          n++;
          if (n == len) begin
            check_frame(k, fr, gap);
            infr = 1'b0; gap = 0;
          end
        end
      end
    end
  endtask

  initial begin
    fork
      decode(0, 10);
      decode(1, 11);
      decode(2, 11);
      decode(3, 10);
    join_none
  end

  // tx may only change on an edge that carried a tick; also count busy clocks
  initial begin
    logic [3:0] prev_tx;
    logic prev_tick, prev_rst;
    prev_tx = 4'hF; prev_tick = 1'b0; prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && !prev_rst) begin
        for (int k = 0; k < 4; k++) begin
          if (tx_v[k] !== prev_tx[k]) begin
            checks++;
            if (!prev_tick) begin
              errors++;
              $display("FAIL edge: dut%0d tx changed to %0b without tick", k, tx_v[k]);
            end
          end
        end
      end
      if (busy_v[0]) busy_cnt++;
      prev_tx = tx_v; prev_tick = baud_tick; prev_rst = rst;
    end
  end

  task automatic send(input int k, input logic [8:0] d, input bit keep);
    int n;
    n = 0;
    @(posedge clk); #1;
    valid_v[k] = 1'b1;
    data_v[k] = d;
    @(negedge clk);
    while (!ready_v[k] && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL send_timeout: dut%0d ready=0 expected 1", k);
    end
    @(posedge clk); #1;
    if (!keep) valid_v[k] = 1'b0;
    check("ready_drop", ready_v[k], 1'b0);
  endtask

  task automatic wait_done(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_v[k] || !ready_v[k]) && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL done_timeout: dut%0d busy=%0b expected 0", k, busy_v[k]);
    end
  endtask

  initial begin
    bit seen;
    int n;
    rst = 1'b1; valid_v = '0; data_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", tx_v[0], 1'b1);
    check("reset_ready", ready_v[0], 1'b1);
    check("reset_busy", busy_v[0], 1'b0);
    rst = 1'b0;

    // 0x55 on default framing: 0,1,0,1,0,1,0,1,0,1
    push(0, 12'h2AA, -1);
    busy_cnt = 0;
    send(0, 9'h055, 1'b0);
    wait_done(0);
    check("busy_clocks", busy_cnt, 40);
    check("idle_tx", tx_v[0], 1'b1);

    // Back-to-back with valid held high
    push(0, 12'h34A, -1);
    push(0, 12'h278, 0);
    send(0, 9'h0A5, 1'b1);
    send(0, 9'h03C, 1'b0);
    n = 0;
    @(negedge clk);
    while (!ready_v[0] && n < 200) begin n++; @(negedge clk); end
    check("ready_back", ready_v[0], 1'b1);
    check("busy_at_reload", busy_v[0], 1'b1);
    wait_done(0);

    // Parity modes
    push(1, 12'h60E, -1);
    send(1, 9'h007, 1'b0);
    wait_done(1);
    push(2, 12'h40E, -1);
    send(2, 9'h007, 1'b0);
    wait_done(2);
    push(2, 12'h600, -1);
    send(2, 9'h000, 1'b0);
    wait_done(2);

    // 7 data bits, 2 stop bits, back to back
    push(3, 12'h3FE, -1);
    push(3, 12'h354, 0);
    send(3, 9'h07F, 1'b1);
    send(3, 9'h02A, 1'b0);
    wait_done(3);

    // Ticks with nothing pending leave the line idle
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy_v[0] || !tx_v[0]) seen = 1'b1;
    end
    check("idle_ticks", seen, 1'b0);

    // Transfer on the same edge as a tick
    push(0, 12'h302, -1);
    n = 0;
    @(negedge clk);
    while (!baud_tick && n < 10) begin n++; @(negedge clk); end
    valid_v[0] = 1'b1; data_v[0] = 9'h081;
    @(posedge clk); #1;
    valid_v[0] = 1'b0;
    @(negedge clk);
    check("coinc_ready", ready_v[0], 1'b0);
    check("coinc_busy0", busy_v[0], 1'b0);
    repeat (3) @(negedge clk);
    check("coinc_busy3", busy_v[0], 1'b0);
    @(negedge clk);
    check("coinc_start", {busy_v[0], tx_v[0]}, 2'b10);
    wait_done(0);

    // Reset in mid-DATA with a byte pending
    send(0, 9'h000, 1'b0);
    send(0, 9'h0FF, 1'b0);
    repeat (12) @(negedge clk);
    check("pre_rst_busy", busy_v[0], 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_tx", tx_v[0], 1'b1);
    check("rst_ready", ready_v[0], 1'b1);
    check("rst_busy", busy_v[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (busy_v[0] || !tx_v[0]) seen = 1'b1;
    end
    check("post_rst_quiet", seen, 1'b0);
    push(0, 12'h21E, -1);
    send(0, 9'h00F, 1'b0);
    wait_done(0);

    repeat (20) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
